// File: rtl/spi_master_tx.sv
// Mode-0 SPI master transmitter with chip-select hold across frames.
// Optional MISO capture for cmd 11 is built when SPI_MISO_CAPTURE_EN is defined.
module spi_master_tx #(
   parameter int CLK_DIV   = 2,
   parameter int MAX_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_start,
   input  logic [1:0]           spi_cmd,
   input  logic [7:0]           spi_width,
   input  logic [MAX_WIDTH-1:0] spi_data,
   input  logic                 spi_miso,
   output logic                 spi_cs_n,
   output logic                 spi_sclk,
   output logic                 spi_mosi,
   output logic [MAX_WIDTH-1:0] spi_rdata,
   output logic                 spi_done,
   output logic                 busy
);

   // state    | meaning
   // IDLE     | waiting for spi_start
   // CS_SETUP | CS low, SCLK low for CLK_DIV cycles before the first bit
   // SHIFT    | low/high SCLK phases, one bit per 2*CLK_DIV cycles
   // CS_HOLD  | CS still low, SCLK low for CLK_DIV cycles
   // CS_GAP   | CS high for 2*CLK_DIV cycles
   // DONE     | one-cycle spi_done pulse
   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      CS_GAP,
      DONE
   } state_t;

   localparam int          MSB      = MAX_WIDTH - 1;
   localparam logic [8:0]  PHASE_LD = 9'(CLK_DIV - 1);
   localparam logic [8:0]  GAP_LD   = 9'(2 * CLK_DIV - 1);
   localparam logic [7:0]  MAXW     = (MAX_WIDTH > 255) ? 8'd255 : 8'(MAX_WIDTH);
   localparam logic [1:0]  CMD_HOLD  = 2'b00;
   localparam logic [1:0]  CMD_CSOFF = 2'b10;

   state_t               state_q, state_d;
   logic [8:0]           cnt_q, cnt_d;
   logic [7:0]           bits_q, bits_d;
   logic [1:0]           cmd_q, cmd_d;
   logic [MAX_WIDTH-1:0] tx_q, tx_d;
   logic                 cs_n_q, cs_n_d;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic [7:0]           w_eff;
   logic [MAX_WIDTH-1:0] tx_load;

`ifdef SPI_MISO_CAPTURE_EN
   localparam logic [1:0] CMD_RD = 2'b11;
   logic [MAX_WIDTH-1:0] rx_q, rx_d;
   logic [MAX_WIDTH-1:0] rdata_q, rdata_d;
`else
   logic unused_miso;
   assign unused_miso = spi_miso;
`endif

   // Data is left-aligned at acceptance so the next bit is always the MSB.
   assign w_eff   = (spi_width > MAXW) ? MAXW : spi_width;
   assign tx_load = spi_data << (MAXW - w_eff);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bits_d  = bits_q;
      cmd_d   = cmd_q;
      tx_d    = tx_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
`ifdef SPI_MISO_CAPTURE_EN
      rx_d    = rx_q;
      rdata_d = rdata_q;
`endif
      case (state_q)
         IDLE: begin
            if (spi_start) begin
               cmd_d  = spi_cmd;
               tx_d   = tx_load;
               bits_d = w_eff;
               cnt_d  = PHASE_LD;
`ifdef SPI_MISO_CAPTURE_EN
               rx_d   = '0;
`endif
               if (spi_cmd == CMD_CSOFF || w_eff == 8'd0) begin
                  if (spi_cmd != CMD_HOLD && !cs_n_q) state_d = CS_HOLD;
                  else                                state_d = DONE;
               end else if (cs_n_q) begin
                  cs_n_d  = 1'b0;
                  state_d = CS_SETUP;
               end else begin
                  state_d = SHIFT;
                  mosi_d  = tx_load[MSB];
                  tx_d    = tx_load << 1;
                  bits_d  = w_eff - 8'd1;
               end
            end
         end
         CS_SETUP: begin
            if (cnt_q == 9'd0) begin
               state_d = SHIFT;
               cnt_d   = PHASE_LD;
               mosi_d  = tx_q[MSB];
               tx_d    = tx_q << 1;
               bits_d  = bits_q - 8'd1;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         SHIFT: begin
            if (cnt_q != 9'd0) begin
               cnt_d = cnt_q - 9'd1;
            end else if (!sclk_q) begin
               sclk_d = 1'b1;
               cnt_d  = PHASE_LD;
            end else begin
               sclk_d = 1'b0;
               cnt_d  = PHASE_LD;
`ifdef SPI_MISO_CAPTURE_EN
               rx_d   = {rx_q[MSB-1:0], spi_miso};
`endif
               if (bits_q == 8'd0) begin
                  state_d = (cmd_q == CMD_HOLD) ? DONE : CS_HOLD;
               end else begin
                  mosi_d = tx_q[MSB];
                  tx_d   = tx_q << 1;
                  bits_d = bits_q - 8'd1;
               end
            end
         end
         CS_HOLD: begin
            if (cnt_q == 9'd0) begin
               cs_n_d  = 1'b1;
               cnt_d   = GAP_LD;
               state_d = CS_GAP;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         CS_GAP: begin
            if (cnt_q == 9'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 9'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef SPI_MISO_CAPTURE_EN
      // Loaded on entry so the captured word is visible during the DONE cycle.
      if (state_d == DONE && state_q != DONE && cmd_d == CMD_RD) rdata_d = rx_d;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bits_q  <= '0;
         cmd_q   <= '0;
         tx_q    <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
`ifdef SPI_MISO_CAPTURE_EN
         rx_q    <= '0;
         rdata_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bits_q  <= bits_d;
         cmd_q   <= cmd_d;
         tx_q    <= tx_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
`ifdef SPI_MISO_CAPTURE_EN
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
`endif
      end
   end

   assign spi_cs_n = cs_n_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_done = (state_q == DONE);
   assign busy     = (state_q != IDLE);
`ifdef SPI_MISO_CAPTURE_EN
   assign spi_rdata = rdata_q;
`else
   assign spi_rdata = '0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: directed test-plan frames plus random frames
// checked against a timing-formula reference model.
module tb_spi_master_tx;

   localparam int D  = 2;
   localparam int MW = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_start = 1'b0;
   logic [1:0]  spi_cmd = 2'b00;
   logic [7:0]  spi_width = 8'd0;
   logic [31:0] spi_data = 32'd0;
   logic        spi_miso = 1'b0;
   logic        spi_cs_n, spi_sclk, spi_mosi, spi_done, busy;
   logic [31:0] spi_rdata;

   int errors = 0;
   int checks = 0;

   // Reference model state carried between frames.
   bit          m_cs_low;
   bit          m_mosi;
   logic [31:0] m_rdata;

   spi_master_tx #(.CLK_DIV(D), .MAX_WIDTH(MW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_start (spi_start),
      .spi_cmd   (spi_cmd),
      .spi_width (spi_width),
      .spi_data  (spi_data),
      .spi_miso  (spi_miso),
      .spi_cs_n  (spi_cs_n),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_rdata (spi_rdata),
      .spi_done  (spi_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lowmask(input int n);
      logic [31:0] one;
      one = 32'd1;
      if (n >= 32) return 32'hFFFF_FFFF;
      return (one << n) - 32'd1;
   endfunction

   // Issues one request at the current negedge and watches it to completion.
   task automatic run_frame(input logic [1:0] cmd, input int width, input logic [31:0] data,
                            input logic [31:0] miso_word, input int poke1, input int poke2,
                            output int done_k, output int rises);
      int n, nbits, s, exp_done, exp_cs_rise, first_rise, dones, budget, idx;
      bit release_cs, low_before, exp_low, timing_ok, cs_ok, busy_ok, prev_sclk, exp_mosi_end;
      logic [31:0] mosi_word, exp_word, rdata_at_done;
      logic        mosi_at_done;

      n          = (width > MW) ? MW : width;
      nbits      = (cmd == 2'b10) ? 0 : n;
      release_cs = (cmd != 2'b00);
      low_before = m_cs_low;
      first_rise = 0;
      exp_cs_rise = 1 << 30;
      if (nbits == 0) begin
         if (release_cs && low_before) begin
            exp_done    = 1 + 3 * D;
            exp_cs_rise = 1 + D;
         end else begin
            exp_done = 1;
         end
      end else begin
         s          = low_before ? 0 : D;
         first_rise = 1 + s + D;
         if (release_cs) begin
            exp_done    = 1 + s + 3 * D + 2 * nbits * D;
            exp_cs_rise = 1 + s + D + 2 * nbits * D;
         end else begin
            exp_done = 1 + s + 2 * nbits * D;
         end
      end

      spi_cmd   = cmd;
      spi_width = 8'(width);
      spi_data  = data;
      spi_start = 1'b1;

      done_k = -1; rises = 0; dones = 0; mosi_word = '0;
      timing_ok = 1; cs_ok = 1; busy_ok = 1; prev_sclk = spi_sclk;
      rdata_at_done = 'x; mosi_at_done = 1'bx;
      budget = 1 + 5 * D + 2 * MW * D + 8;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == poke1 || k == poke2) begin
            spi_start = 1'b1;
            spi_cmd   = 2'($urandom);
            spi_width = 8'($urandom);
            spi_data  = $urandom;
         end else begin
            spi_start = 1'b0;
         end
         exp_low = (low_before || nbits > 0) && !(k >= exp_cs_rise);
         if (spi_cs_n !== !exp_low) cs_ok = 0;
         if (spi_sclk === 1'b1 && prev_sclk == 1'b0) begin
            if (k != first_rise + 2 * D * rises) timing_ok = 0;
            mosi_word = {mosi_word[30:0], spi_mosi};
            rises++;
         end
         prev_sclk = spi_sclk;
         if (spi_sclk === 1'b0) begin
            if (rises < n) begin
               idx = n - 1 - rises;
               spi_miso = miso_word[5'(idx)];
            end else begin
               spi_miso = 1'($urandom);
            end
         end
         if (done_k < 0) begin
            if (busy !== 1'b1) busy_ok = 0;
         end else if (busy !== 1'b0) begin
            busy_ok = 0;
         end
         if (spi_done === 1'b1) begin
            dones++;
            if (done_k < 0) begin
               done_k        = k;
               rdata_at_done = spi_rdata;
               mosi_at_done  = spi_mosi;
            end
         end
         if (done_k >= 0 && k == done_k + 1) break;
      end
      spi_start = 1'b0;

      exp_word     = (nbits == 0) ? 32'd0 : (data & lowmask(n));
      exp_mosi_end = (nbits > 0) ? data[0] : m_mosi;
`ifdef SPI_MISO_CAPTURE_EN
      if (cmd == 2'b11) m_rdata = (nbits == 0) ? 32'd0 : (miso_word & lowmask(n));
`else
      m_rdata = 32'd0;
`endif
      chk("done_cycle",  64'(done_k), 64'(exp_done));
      chk("done_pulses", 64'(dones), 64'd1);
      chk("sclk_rises",  64'(rises), 64'(nbits));
      chk("mosi_bits",   64'(mosi_word), 64'(exp_word));
      chk("sclk_timing", 64'(timing_ok), 64'd1);
      chk("cs_n_trace",  64'(cs_ok), 64'd1);
      chk("busy_trace",  64'(busy_ok), 64'd1);
      chk("mosi_hold",   64'(mosi_at_done), 64'(exp_mosi_end));
      chk("rdata",       64'(rdata_at_done), 64'(m_rdata));

      m_cs_low = release_cs ? 1'b0 : (m_cs_low || nbits > 0);
      m_mosi   = exp_mosi_end;
   endtask

   initial begin
      int dk, r, total, k;
      logic [1:0] rc;
      int rw;
      logic [31:0] exp_rd;

      m_cs_low = 0; m_mosi = 0; m_rdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({spi_cs_n, spi_sclk, spi_mosi, spi_done, busy}), 64'(5'b10000));
      chk("reset_rdata",   64'(spi_rdata), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_frame(2'b01, 8, 32'h06, $urandom, 0, 0, dk, r);
      chk("tp_cmd01_done_t41", 64'(dk), 64'd41);

      total = 0;
      run_frame(2'b00, 8,  32'h02,     $urandom, 0, 0, dk, r); total += r;
      run_frame(2'b00, 24, 32'h000000, $urandom, 0, 0, dk, r); total += r;
      run_frame(2'b00, 8,  32'hA5,     $urandom, 0, 0, dk, r); total += r;
      run_frame(2'b10, 0,  32'h0,      $urandom, 0, 0, dk, r); total += r;
      chk("page_sclk_edges", 64'(total), 64'd40);
      chk("page_final_done", 64'(dk), 64'(3 * D + 1));

      run_frame(2'b11, 16, $urandom, 32'h0000EF14, 0, 0, dk, r);
`ifdef SPI_MISO_CAPTURE_EN
      exp_rd = 32'h0000EF14;
`else
      exp_rd = 32'h0;
`endif
      chk("read_rdata_held", 64'(spi_rdata), 64'(exp_rd));

      // cmd 01, width 16 from CS high: CS_GAP spans cycles 69..72, done at 73.
      run_frame(2'b01, 16, $urandom, $urandom, 20, 70, dk, r);

      spi_cmd = 2'b01; spi_width = 8'd24; spi_data = $urandom; spi_start = 1'b1;
      r = 0;
      for (k = 0; k < 200; k++) begin
         @(posedge clk);
         @(negedge clk);
         spi_start = 1'b0;
         if (spi_sclk === 1'b1) begin
            r++;
            repeat (D) @(negedge clk);
            if (r == 5) break;
         end
      end
      chk("reset_reached_bit4", 64'(r), 64'd5);
      rst_n = 1'b0;
      #1;
      chk("midframe_reset_outputs", 64'({spi_cs_n, spi_sclk, busy, spi_done, spi_mosi}), 64'(5'b10000));
      @(negedge clk);
      rst_n = 1'b1;
      m_cs_low = 0; m_mosi = 0; m_rdata = '0;
      @(negedge clk);
      run_frame(2'b01, 12, $urandom, $urandom, 0, 0, dk, r);

      run_frame(2'b01, 0, $urandom, $urandom, 0, 0, dk, r);
      chk("width0_done_t1", 64'(dk), 64'd1);
      run_frame(2'b01, 40, $urandom, $urandom, 0, 0, dk, r);
      chk("width40_clamped", 64'(r), 64'd32);

      for (int i = 0; i < 24; i++) begin
         rc = 2'($urandom_range(0, 3));
         rw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(33, 255)) : int'($urandom_range(0, 32));
         run_frame(rc, rw, $urandom, $urandom, 0, 0, dk, r);
      end
      run_frame(2'b10, 0, 32'h0, $urandom, 0, 0, dk, r);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Bit-level SPI master (mode 0) that sits directly downstream of the W25Q16 command-sequencing FSM. It accepts one frame request per `spi_start` pulse (width, command, right-aligned data), drives `spi_cs_n`/`spi_sclk`/`spi_mosi` to the flash, and returns a one-cycle `spi_done` that the sequencer uses to issue the next frame. Chip-select may be held low across frames so that one page-program (opcode, 24-bit address, data bytes) is sent as consecutive requests.

## Interface
Parameters:
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles; legal 1..255.
- `MAX_WIDTH`, 32: maximum frame length in bits; also the width of `spi_data`/`spi_rdata`.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_start` in 1: frame request, one-cycle pulse; sampled only in IDLE.
- `spi_cmd` in 2: 00 write and hold CS low; 01 write and release CS; 10 release CS only (no bits); 11 write+read and release CS.
- `spi_width` in 8: frame length in bits.
- `spi_data` in MAX_WIDTH: transmit data, right-aligned; bit `spi_width-1` is sent first.
- `spi_miso` in 1: flash serial output.
- `spi_cs_n` out 1: chip select, active low.
- `spi_sclk` out 1: serial clock, idles low.
- `spi_mosi` out 1: serial data to flash.
- `spi_rdata` out MAX_WIDTH: captured read data, right-aligned.
- `spi_done` out 1: one-cycle pulse at end of each accepted request.
- `busy` out 1: high from the cycle after acceptance until the cycle `spi_done` is high, inclusive.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `spi_rdata`=0, `spi_done`=0, `busy`=0, state IDLE. Reset mid-frame aborts immediately; CS released asynchronously.
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP, DONE.
- IDLE: on `spi_start`, latch `spi_cmd`, `spi_width`, `spi_data`. Clamp width >MAX_WIDTH to MAX_WIDTH.
  - cmd 10: go to CS_HOLD if CS is low, otherwise DONE.
  - Width 0 with cmd 00/01/11: no bits are shifted. Go to CS_HOLD (01/11 with CS low) or DONE.
  - Otherwise: if CS is high, assert CS and go to CS_SETUP; else go to SHIFT.
- CS_SETUP: SCLK low for CLK_DIV cycles, then SHIFT.
- SHIFT: each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - MOSI updates on the first cycle of the low phase and is MSB-first.
  - MISO is sampled on the last cycle of the high phase and shifted into the read register LSB-first.
  - After the last high phase, SCLK returns low. cmd 00 goes to DONE; other commands go to CS_HOLD.
- CS_HOLD: SCLK low, CS low for CLK_DIV cycles, then CS deasserts and the block goes to CS_GAP.
- CS_GAP: CS high for 2·CLK_DIV cycles, then DONE.
- DONE: `spi_done`=1 for one cycle; then IDLE. `spi_rdata` updates in DONE for cmd 11 only; it is held otherwise.
- `spi_start` while not IDLE is ignored; no queuing.
- MOSI holds its last bit between frames and is 0 after reset.

## Timing
- Let acceptance occur on cycle T, CS high before the request, D=CLK_DIV, and N bits.
- `spi_cs_n` falls at T+1.
- First SCLK rise occurs at T+1+2D.
- Last SCLK fall occurs at T+1+D+2ND.
- cmd 00: `spi_done` at T+1+D+2ND.
- cmd 01/11: CS rises at T+1+2D+2ND; `spi_done` at T+1+4D+2ND.
- With CS already low, subtract D: there is no CS_SETUP.
- The earliest next acceptance is the cycle after `spi_done`, so the back-to-back request gap is 1 cycle.
- For D=2, N=8, cmd 01 from CS high: CS low at T+1, first rise at T+5, done at T+41.

## Configuration
- `SPI_MISO_CAPTURE_EN` defined: the read shift register and `spi_rdata` are implemented, and cmd 11 captures MISO.
- Not defined: `spi_rdata` is tied to 0, `spi_miso` is unused, and cmd 11 behaves exactly as cmd 01.

## Test plan
- Reset, then cmd 01, width 8, data 0x06, D=2:
  - MOSI bits 0,0,0,0,0,1,1,0 on 8 rising edges.
  - CS rises at T+37; `spi_done` at T+41; `busy` deasserts after done.
- Page program: cmd 00/8/0x02, then 00/24/0x000000, then 00/8/0xA5, then 10/0:
  - CS stays low across all frames; 40 SCLK edges total.
  - Final `spi_done` occurs 3D+1 cycles after the cmd-10 acceptance.
- With `SPI_MISO_CAPTURE_EN`, cmd 11, width 16, MISO drives 0xEF14: `spi_rdata`=0x0000EF14 in the DONE cycle.
- `spi_start` pulsed mid-SHIFT and during CS_GAP: both ignored; exactly one `spi_done`.
- `rst_n` low during bit 4 of a 24-bit frame: CS=1, SCLK=0, `busy`=0 immediately.
  - After release, a new cmd-01 frame runs with correct timing.
- Edge cases:
  - Width 0, cmd 01, CS high: `spi_done` at T+1 with no SCLK edges.
  - Width 40: treated as 32 bits.
